// File: rtl/sdp_ram_pkg.sv
// Shared constants and types for the 1024x36 simple dual-port RAM.
// Optional feature macro used by this RAM family: SDP_RAM_OUT_PIPE_EN.
package sdp_ram_pkg;

    localparam int DATA_W = 36;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/sdp_ram_array.sv
// Bare storage: one write port and one registered read-first read port.
// No reset, so the array and its read register map onto a single block RAM.
module sdp_ram_array
    import sdp_ram_pkg::*;
#(
    parameter int ARR_DATA_W = sdp_ram_pkg::DATA_W,
    parameter int ARR_ADDR_W = sdp_ram_pkg::ADDR_W,
    parameter int ARR_DEPTH  = sdp_ram_pkg::DEPTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ARR_ADDR_W-1:0] wr_addr,
    input  logic [ARR_ADDR_W-1:0] rd_addr,
    input  logic [ARR_DATA_W-1:0] din,
    output logic [ARR_DATA_W-1:0] rd_data
);

    logic [ARR_DATA_W-1:0] mem [ARR_DEPTH];

    // Both updates are non-blocking, so a same-address read returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= din;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sdp_ram_1024x36_r4w4.sv
// Top of the 1024x36 simple dual-port RAM: reset on dout and optional output stage.
// Define SDP_RAM_OUT_PIPE_EN to add a second output register (read latency 2).
module sdp_ram_1024x36_r4w4
    import sdp_ram_pkg::*;
#(
    parameter int RAM_DATA_W = sdp_ram_pkg::DATA_W,
    parameter int RAM_ADDR_W = sdp_ram_pkg::ADDR_W,
    parameter int RAM_DEPTH  = sdp_ram_pkg::DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [RAM_ADDR_W-1:0] wr_addr,
    input  logic [RAM_ADDR_W-1:0] rd_addr,
    input  logic [RAM_DATA_W-1:0] din,
    output logic [RAM_DATA_W-1:0] dout
);

    if (RAM_DEPTH != (1 << RAM_ADDR_W)) begin : g_depth_check
        $error("sdp_ram_1024x36_r4w4: DEPTH must equal 2**ADDR_W");
    end

    logic [RAM_DATA_W-1:0] rd_data;
    logic                  rst_q;
    logic [RAM_DATA_W-1:0] rd_masked;

    sdp_ram_array #(
        .ARR_DATA_W(RAM_DATA_W),
        .ARR_ADDR_W(RAM_ADDR_W),
        .ARR_DEPTH (RAM_DEPTH)
    ) u_array (
        .clk    (clk),
        .we     (we),
        .wr_addr(wr_addr),
        .rd_addr(rd_addr),
        .din    (din),
        .rd_data(rd_data)
    );

    // Reset is applied as a mask behind the array register instead of inside it,
    // which is cycle-identical to clearing that register but keeps it reset-free.
    always_ff @(posedge clk) begin
        rst_q <= rst;
    end

    assign rd_masked = rst_q ? '0 : rd_data;

`ifdef SDP_RAM_OUT_PIPE_EN
    logic [RAM_DATA_W-1:0] pipe_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= rd_masked;
        end
    end

    assign dout = pipe_q;
`else
    assign dout = rd_masked;
`endif

endmodule

// File: tb/tb_sdp_ram_1024x36_r4w4.sv
// Directed self-checking bench for sdp_ram_1024x36_r4w4, both latency builds.
module tb_sdp_ram_1024x36_r4w4;
    import sdp_ram_pkg::*;

`ifdef SDP_RAM_OUT_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic  clk = 1'b0;
    logic  rst;
    logic  we;
    addr_t wr_addr;
    addr_t rd_addr;
    data_t din;
    data_t dout;

    int totalCount = 0;
    int badCount   = 0;

    data_t model [DEPTH];
    bit    known [DEPTH];
    data_t p0v, p1v;
    bit    p0k, p1k;
    data_t sweepVal [512];

    sdp_ram_1024x36_r4w4 dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .wr_addr(wr_addr),
        .rd_addr(rd_addr),
        .din    (din),
        .dout   (dout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input data_t observed, input data_t expected);
        totalCount++;
        if (observed !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle, advance the reference pipeline, then sample 1ns after the edge.
    task automatic applyStimulus(input logic r, input logic w, input addr_t wa,
                                 input addr_t ra, input data_t d);
        data_t sv;
        bit    sk;
        rst = r; we = w; wr_addr = wa; rd_addr = ra; din = d;
        sv = r ? '0 : model[ra];
        sk = r ? 1'b1 : known[ra];
        p1v = r ? '0 : p0v;
        p1k = r ? 1'b1 : p0k;
        p0v = sv;
        p0k = sk;
        if (w) begin
            model[wa] = d;
            known[wa] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkModel(input string tag);
        data_t ev;
        bit    ek;
        ev = (LAT == 1) ? p0v : p1v;
        ek = (LAT == 1) ? p0k : p1k;
        if (ek) checkOutput(tag, dout, ev);
    endtask

    task automatic readExpect(input addr_t a, input data_t expected, input string tag);
        repeat (LAT) applyStimulus(1'b0, 1'b0, '0, a, '0);
        checkOutput(tag, dout, expected);
    endtask

    initial begin
        logic [63:0] rnd;
        p0k = 1'b0; p1k = 1'b0; p0v = '0; p1v = '0;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

        // Reset state
        applyStimulus(1'b1, 1'b0, '0, '0, '0);
        checkOutput("reset_edge1", dout, 36'h0);
        applyStimulus(1'b1, 1'b0, '0, '0, '0);
        checkOutput("reset_edge2", dout, 36'h0);

        // Basic write then read after 5 idle cycles
        applyStimulus(1'b0, 1'b1, 10'd1, 10'd0, 36'h00000000F);
        repeat (5) applyStimulus(1'b0, 1'b0, 10'd1, 10'd0, 36'hFFFFFFFFF);
        readExpect(10'd1, 36'h00000000F, "basic_read");

        // Reset mid-read keeps memory; a write during reset is still performed
        applyStimulus(1'b1, 1'b1, 10'd20, 10'd1, 36'h000000ABC);
        checkOutput("rst_mid_edge1", dout, 36'h0);
        applyStimulus(1'b1, 1'b0, 10'd20, 10'd1, 36'h0);
        checkOutput("rst_mid_edge2", dout, 36'h0);
        readExpect(10'd1, 36'h00000000F, "after_rst_read");
        readExpect(10'd20, 36'h000000ABC, "write_in_rst");

        // Write inhibit
        applyStimulus(1'b0, 1'b1, 10'd5, 10'd0, 36'h123456789);
        applyStimulus(1'b0, 1'b0, 10'd5, 10'd0, 36'hFFFFFFFFF);
        readExpect(10'd5, 36'h123456789, "write_inhibit");

        // Top address vs address 0, then back-to-back reads
        applyStimulus(1'b0, 1'b1, 10'd1023, 10'd5, 36'hA5A5A5A5A);
        applyStimulus(1'b0, 1'b1, 10'd0, 10'd5, 36'h5A5A5A5A5);
        readExpect(10'd1023, 36'hA5A5A5A5A, "top_addr");
        readExpect(10'd0, 36'h5A5A5A5A5, "addr0");
        applyStimulus(1'b0, 1'b0, '0, 10'd1023, '0);
        checkModel("b2b_1023");
        applyStimulus(1'b0, 1'b0, '0, 10'd0, '0);
        checkModel("b2b_0");
        applyStimulus(1'b0, 1'b0, '0, 10'd5, '0);
        checkModel("b2b_5");

        // Read-during-write, same address: old data first, new data next read
        applyStimulus(1'b0, 1'b1, 10'd7, 10'd0, 36'h111111111);
        applyStimulus(1'b0, 1'b1, 10'd7, 10'd7, 36'h222222222);
        repeat (LAT - 1) applyStimulus(1'b0, 1'b0, '0, 10'd7, '0);
        checkOutput("rdw_same_old", dout, 36'h111111111);
        readExpect(10'd7, 36'h222222222, "rdw_same_new");

        // Read-during-write, different addresses
        applyStimulus(1'b0, 1'b1, 10'd8, 10'd0, 36'h444444444);
        applyStimulus(1'b0, 1'b1, 10'd9, 10'd8, 36'h333333333);
        repeat (LAT - 1) applyStimulus(1'b0, 1'b0, '0, 10'd8, '0);
        checkOutput("rdw_diff", dout, 36'h444444444);
        readExpect(10'd9, 36'h333333333, "rdw_diff_wr");

        // Sweep: write random data while reading the same address
        for (int i = 0; i < 512; i++) begin
            rnd = {$urandom(), $urandom()};
            sweepVal[i] = rnd[35:0];
            applyStimulus(1'b0, 1'b1, addr_t'(i), addr_t'(i), rnd[35:0]);
            checkModel("sweep_wr");
        end
        for (int i = 0; i < 512; i++) begin
            applyStimulus(1'b0, 1'b0, '0, addr_t'(i), '0);
            checkModel("sweep_rd");
        end
        repeat (LAT - 1) applyStimulus(1'b0, 1'b0, '0, 10'd511, '0);
        checkOutput("sweep_last", dout, sweepVal[511]);
        readExpect(10'd3, sweepVal[3], "sweep_addr3");

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule

// File: doc/sdp_ram_1024x36_r4w4.md
Name: sdp_ram_1024x36_r4w4

Overview:
- Simple dual-port synchronous RAM: 1024 words x 36 bits, one write port, one read port, single clock.
- Non-split: one logical array, not partitioned into narrower sub-RAMs.
- Used as a generic storage macro. Must map to one block-RAM-style array.
- Gate-level netlist must be cycle-equivalent to the RTL.

Parameters:
- DATA_W, 36, word width in bits.
- ADDR_W, 10, address width in bits.
- DEPTH, 1024, number of words. Must equal 2**ADDR_W; elaboration error otherwise.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset; clears output register only.
- we  input  1  write enable.
- wr_addr  input  ADDR_W  write address.
- rd_addr  input  ADDR_W  read address, always enabled.
- din  input  DATA_W  write data.
- dout  output  DATA_W  registered read data.

Behaviour:
- Write: at posedge clk with we=1, mem[wr_addr] <= din.
  - With we=0, memory is unchanged regardless of wr_addr or din.
- Read: at every posedge clk, dout <= mem[rd_addr]. There is no read enable.
- Read latency is 1 cycle: rd_addr sampled at edge N appears on dout after edge N and is stable until edge N+1.
- Read-during-write, same address: read-first. dout shows the old contents; the new data is visible on the next read of that address.
- Read-during-write, different addresses: fully independent.
- Reset:
  - rst=1 at posedge: dout <= 0. The read of that edge is suppressed.
  - A write with we=1 during reset is still performed. Memory is never cleared by reset.
  - Reset asserted mid-operation: memory contents retained; dout returns to 0 for each cycle rst is high.
  - The first read after rst deasserts returns the stored data.
- Power-up: memory contents are undefined (X in simulation) until written. dout is undefined until the first reset or first read.
- Addresses are exactly ADDR_W bits; no out-of-range case exists. Address 1023 is a normal word, with no wrap logic.
- All DATA_W bits are written together; no byte enables.

Optional Feature:
- Macro: SDP_RAM_OUT_PIPE_EN.
- Defined:
  - A second output register is added after the array read register. Read latency becomes 2 cycles.
  - rst clears both registers to 0.
  - Read-first semantics are unchanged, relative to the array read edge.
- Undefined: single output register, latency 1, as described above.

Decomposition:
- Shared package sdp_ram_pkg holds:
  - Constants DATA_W=36, ADDR_W=10, DEPTH=1024.
  - Typedefs addr_t (logic [ADDR_W-1:0]) and data_t (logic [DATA_W-1:0]).
- One natural sub-module, sdp_ram_array:
  - Contains the bare storage: write port plus registered read-first read, no reset.
  - The top module adds rst handling on dout and the optional output pipeline register.

Test Plan:
- Basic write/read: write 36'h00000000F to addr 1 with we=1; 5 cycles later set rd_addr=1, we=0 -> dout=36'h00000000F one edge later.
- Sweep: for i=0..511, write a random value to addr i while rd_addr=i -> dout shows the old value each cycle. Then for i=0..511 with we=0, read addr i -> dout equals the value written to i, at latency 1. Golden model and netlist must match bit-exactly, with no X on written words.
- Write inhibit: we=0, wr_addr=5, din=36'hFFFFFFFFF after writing 36'h123456789 to addr 5 -> reading addr 5 returns 36'h123456789.
- Top address: write 36'hA5A5A5A5A to addr 1023 and 36'h5A5A5A5A5 to addr 0 -> reading 1023 and then 0 returns each value unchanged (no aliasing).
- Reset mid-read: with dout=36'h00000000F, assert rst for 2 cycles -> dout=0 on both edges. After release, rd_addr=1 -> dout=36'h00000000F (memory retained).
- With SDP_RAM_OUT_PIPE_EN defined: repeat the basic write/read case -> data appears 2 edges after rd_addr is sampled.
